// File: rtl/ex_mem_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg_pkg
// Description : Shared pipeline constants, MEM/WB control bundle, ALU codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_reg_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_REG_AW = 5;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef enum logic [3:0] {
        c_ALU_ADD  = 4'd0,
        c_ALU_SUB  = 4'd1,
        c_ALU_AND  = 4'd2,
        c_ALU_OR   = 4'd3,
        c_ALU_XOR  = 4'd4,
        c_ALU_SLT  = 4'd5,
        c_ALU_SLTU = 4'd6,
        c_ALU_SLL  = 4'd7,
        c_ALU_SRL  = 4'd8,
        c_ALU_SRA  = 4'd9,
        c_ALU_LUI  = 4'd10
    } alu_ctrl_e;

    // Kill every side effect of an invalid slot; writes to x0 are never real.
    function automatic mem_ctrl_t qualify_ctrl(input mem_ctrl_t c,
                                               input logic      valid,
                                               input logic      rd_nonzero);
        mem_ctrl_t q;
        q.reg_write  = c.reg_write  & valid & rd_nonzero;
        q.mem_to_reg = c.mem_to_reg & valid;
        q.mem_read   = c.mem_read   & valid;
        q.mem_write  = c.mem_write  & valid;
        return q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg_if
// Description : EX-side inputs and MEM-side outputs of the EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_reg_if
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int REG_AW = c_REG_AW
);
    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] rs2_data_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              reg_write_i;
    logic              mem_to_reg_i;
    logic              mem_read_i;
    logic              mem_write_i;

    logic              valid_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [DATA_W-1:0] wr_data_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              reg_write_o;
    logic              mem_to_reg_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic              fwd_we_o;
    logic [REG_AW-1:0] fwd_rd_o;
    logic [DATA_W-1:0] fwd_data_o;

    modport master (
        output stall_i, flush_i, valid_i, alu_result_i, rs2_data_i, rd_addr_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
        input  valid_o, alu_result_o, wr_data_o, rd_addr_o, reg_write_o,
               mem_to_reg_o, mem_read_o, mem_write_o, fwd_we_o, fwd_rd_o,
               fwd_data_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, alu_result_i, rs2_data_i, rd_addr_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
        output valid_o, alu_result_o, wr_data_o, rd_addr_o, reg_write_o,
               mem_to_reg_o, mem_read_o, mem_write_o, fwd_we_o, fwd_rd_o,
               fwd_data_o
    );

endinterface
`default_nettype wire

// File: rtl/ex_mem_perf.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_perf
// Description : Retired / bubble / stall event counters (EX_MEM_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_perf (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_retire,
    input  wire logic        i_bubble,
    input  wire logic        i_stall,
    output logic [31:0]      o_retired,
    output logic [31:0]      o_bubble,
    output logic [31:0]      o_stall
);
    logic [31:0] r_retired_q, r_bubble_q, r_stall_q;
    logic [31:0] w_retired_d, w_bubble_d, w_stall_d;

    // Plain 32-bit adds wrap 0xFFFFFFFF -> 0 on their own.
    always_comb begin
        w_retired_d = r_retired_q + {31'd0, i_retire};
        w_bubble_d  = r_bubble_q  + {31'd0, i_bubble};
        w_stall_d   = r_stall_q   + {31'd0, i_stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_q <= '0;
            r_bubble_q  <= '0;
            r_stall_q   <= '0;
        end else begin
            r_retired_q <= w_retired_d;
            r_bubble_q  <= w_bubble_d;
            r_stall_q   <= w_stall_d;
        end
    end

    assign o_retired = r_retired_q;
    assign o_bubble  = r_bubble_q;
    assign o_stall   = r_stall_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register with stall, flush, x0 suppression.
//               Optional event counters when EX_MEM_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int REG_AW = c_REG_AW
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    ex_mem_reg_if.slave  bus
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]  perf_retired_o,
    output logic [31:0]  perf_bubble_o,
    output logic [31:0]  perf_stall_o
`endif
);
    logic              r_valid_q,  w_valid_d;
    logic [DATA_W-1:0] r_alu_q,    w_alu_d;
    logic [DATA_W-1:0] r_wdata_q,  w_wdata_d;
    logic [REG_AW-1:0] r_rd_q,     w_rd_d;
    mem_ctrl_t         r_ctrl_q,   w_ctrl_d;
    mem_ctrl_t         w_ctrl_in;

    assign w_ctrl_in = '{reg_write:  bus.reg_write_i,
                         mem_to_reg: bus.mem_to_reg_i,
                         mem_read:   bus.mem_read_i,
                         mem_write:  bus.mem_write_i};

    always_comb begin
        w_valid_d = r_valid_q;
        w_alu_d   = r_alu_q;
        w_wdata_d = r_wdata_q;
        w_rd_d    = r_rd_q;
        w_ctrl_d  = r_ctrl_q;
        if (bus.flush_i) begin
            // Data/rd deliberately left untouched: a bubble has no payload.
            w_valid_d = 1'b0;
            w_ctrl_d  = '0;
        end else if (!bus.stall_i) begin
            w_valid_d = bus.valid_i;
            w_alu_d   = bus.alu_result_i;
            w_wdata_d = bus.rs2_data_i;
            w_rd_d    = bus.rd_addr_i;
            w_ctrl_d  = qualify_ctrl(w_ctrl_in, bus.valid_i,
                                     bus.rd_addr_i != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_alu_q   <= '0;
            r_wdata_q <= '0;
            r_rd_q    <= '0;
            r_ctrl_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_alu_q   <= w_alu_d;
            r_wdata_q <= w_wdata_d;
            r_rd_q    <= w_rd_d;
            r_ctrl_q  <= w_ctrl_d;
        end
    end

    assign bus.valid_o      = r_valid_q;
    assign bus.alu_result_o = r_alu_q;
    assign bus.wr_data_o    = r_wdata_q;
    assign bus.rd_addr_o    = r_rd_q;
    assign bus.reg_write_o  = r_ctrl_q.reg_write;
    assign bus.mem_to_reg_o = r_ctrl_q.mem_to_reg;
    assign bus.mem_read_o   = r_ctrl_q.mem_read;
    assign bus.mem_write_o  = r_ctrl_q.mem_write;

    // Loads are not forwardable from EX/MEM; their data arrives in MEM/WB.
    assign bus.fwd_we_o   = r_valid_q & r_ctrl_q.reg_write & ~r_ctrl_q.mem_to_reg;
    assign bus.fwd_rd_o   = r_rd_q;
    assign bus.fwd_data_o = r_alu_q;

`ifdef EX_MEM_PERF_EN
    logic w_retire, w_bubble, w_stall;

    assign w_retire = ~rst_i & ~bus.flush_i & ~bus.stall_i &  bus.valid_i;
    assign w_bubble = ~rst_i & (bus.flush_i | (~bus.stall_i & ~bus.valid_i));
    assign w_stall  = ~rst_i & ~bus.flush_i & bus.stall_i;

    ex_mem_perf u_perf (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_retire  (w_retire),
        .i_bubble  (w_bubble),
        .i_stall   (w_stall),
        .o_retired (perf_retired_o),
        .o_bubble  (perf_bubble_o),
        .o_stall   (perf_stall_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_reg
// Description : Self-checking bench: directed table, stall/flush sequences,
//               randomized traffic against a record-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;

    logic clk;
    logic rst;

    ex_mem_reg_if bus ();

`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_retired, perf_bubble, perf_stall;
`endif

    ex_mem_reg dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus.slave)
`ifdef EX_MEM_PERF_EN
        ,
        .perf_retired_o (perf_retired),
        .perf_bubble_o  (perf_bubble),
        .perf_stall_o   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw, m2r, mr, mw;
        logic        care;  // data/rd fields meaningful
    } st_t;

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        logic        rw, m2r, mr, mw;
        st_t         exp;
    } vec_t;

    int  n_vec = 0;
    int  n_err = 0;
    st_t model;

    always @(posedge clk) begin
        assert (!(bus.mem_read_i && bus.mem_write_i))
            else $error("illegal mem_read_i & mem_write_i stimulus");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input st_t e);
        chk({tag, " valid_o"},      {31'd0, bus.valid_o},      {31'd0, e.valid});
        chk({tag, " reg_write_o"},  {31'd0, bus.reg_write_o},  {31'd0, e.rw});
        chk({tag, " mem_to_reg_o"}, {31'd0, bus.mem_to_reg_o}, {31'd0, e.m2r});
        chk({tag, " mem_read_o"},   {31'd0, bus.mem_read_o},   {31'd0, e.mr});
        chk({tag, " mem_write_o"},  {31'd0, bus.mem_write_o},  {31'd0, e.mw});
        chk({tag, " fwd_we_o"},     {31'd0, bus.fwd_we_o},
            {31'd0, e.valid & e.rw & ~e.m2r});
        if (e.care) begin
            chk({tag, " alu_result_o"}, bus.alu_result_o, e.alu);
            chk({tag, " wr_data_o"},    bus.wr_data_o,    e.wd);
            chk({tag, " rd_addr_o"},    {27'd0, bus.rd_addr_o}, {27'd0, e.rd});
            chk({tag, " fwd_rd_o"},     {27'd0, bus.fwd_rd_o},  {27'd0, e.rd});
            chk({tag, " fwd_data_o"},   bus.fwd_data_o,   e.alu);
        end
    endtask

    // Record-level model: one update per clock edge from the priority rules.
    task automatic model_edge();
        if (rst) begin
            model = '{valid: 1'b0, alu: 32'd0, wd: 32'd0, rd: 5'd0,
                      rw: 1'b0, m2r: 1'b0, mr: 1'b0, mw: 1'b0, care: 1'b1};
        end else if (bus.flush_i) begin
            model.valid = 1'b0;
            model.rw = 1'b0; model.m2r = 1'b0; model.mr = 1'b0; model.mw = 1'b0;
            model.care = 1'b0;
        end else if (!bus.stall_i) begin
            model.valid = bus.valid_i;
            model.alu   = bus.alu_result_i;
            model.wd    = bus.rs2_data_i;
            model.rd    = bus.rd_addr_i;
            model.rw    = bus.reg_write_i & bus.valid_i & (bus.rd_addr_i != 5'd0);
            model.m2r   = bus.mem_to_reg_i & bus.valid_i;
            model.mr    = bus.mem_read_i & bus.valid_i;
            model.mw    = bus.mem_write_i & bus.valid_i;
            model.care  = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic fl,
                         input logic v, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic mr,
                         input logic mw);
        rst              = r;
        bus.stall_i      = st;
        bus.flush_i      = fl;
        bus.valid_i      = v;
        bus.alu_result_i = alu;
        bus.rs2_data_i   = rs2;
        bus.rd_addr_i    = rd;
        bus.reg_write_i  = rw;
        bus.mem_to_reg_i = m2r;
        bus.mem_read_i   = mr;
        bus.mem_write_i  = mw;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_random(input int p_rst, input int p_flush,
                                input int p_stall);
        logic [1:0] kind;
        kind = 2'($urandom_range(0, 2));  // 0 alu, 1 load, 2 store
        drive(($urandom_range(0, 99) < p_rst),
              ($urandom_range(0, 99) < p_stall),
              ($urandom_range(0, 99) < p_flush),
              1'($urandom),
              $urandom, $urandom,
              5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
              (kind != 2'd2) ? 1'($urandom) : 1'b0,
              kind == 2'd1, kind == 2'd1, kind == 2'd2);
    endtask

    vec_t tbl[9];
    st_t  held;

    initial begin
        // rst stall flush valid alu rs2 rd rw m2r mr mw -> expected record
        tbl[0] = '{1,0,0,1, 32'h0000FFFF, 32'h12345678, 5'd7, 1,0,0,0,
                   '{0, 32'h0, 32'h0, 5'd0, 0,0,0,0, 1}};
        tbl[1] = '{0,0,0,1, 32'h00000010, 32'h00000055, 5'd5, 1,0,0,0,
                   '{1, 32'h10, 32'h55, 5'd5, 1,0,0,0, 1}};
        tbl[2] = '{0,0,0,1, 32'h00000020, 32'h00000066, 5'd0, 1,0,0,0,
                   '{1, 32'h20, 32'h66, 5'd0, 0,0,0,0, 1}};
        tbl[3] = '{0,0,0,0, 32'h00000030, 32'h00000077, 5'd3, 1,0,0,1,
                   '{0, 32'h30, 32'h77, 5'd3, 0,0,0,0, 1}};
        tbl[4] = '{0,0,0,1, 32'h00000040, 32'hDEADBEEF, 5'd0, 0,0,0,1,
                   '{1, 32'h40, 32'hDEADBEEF, 5'd0, 0,0,0,1, 1}};
        tbl[5] = '{0,1,1,1, 32'h00000044, 32'hDEADBEEF, 5'd0, 0,0,0,1,
                   '{0, 32'h0, 32'h0, 5'd0, 0,0,0,0, 0}};
        tbl[6] = '{0,0,0,1, 32'h00000080, 32'h00000088, 5'd9, 1,1,1,0,
                   '{1, 32'h80, 32'h88, 5'd9, 1,1,1,0, 1}};
        tbl[7] = '{1,1,1,1, 32'h00000090, 32'h00000091, 5'd4, 1,0,0,1,
                   '{0, 32'h0, 32'h0, 5'd0, 0,0,0,0, 1}};
        tbl[8] = '{0,1,0,1, 32'h00000099, 32'h0000009A, 5'd6, 1,0,0,0,
                   '{0, 32'h0, 32'h0, 5'd0, 0,0,0,0, 1}};

        drive(1,0,0,0, 0,0,0, 0,0,0,0);
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].valid,
                  tbl[i].alu, tbl[i].rs2, tbl[i].rd,
                  tbl[i].rw, tbl[i].m2r, tbl[i].mr, tbl[i].mw);
            cmp_all($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // Three-cycle stall with changing inputs, release on the fourth edge.
        drive(0,0,0,1, 32'h000000A0, 32'h000000A1, 5'd10, 1,0,0,0);
        held = '{1, 32'hA0, 32'hA1, 5'd10, 1,0,0,0, 1};
        cmp_all("pre_stall", held);
        for (int i = 0; i < 3; i++) begin
            drive(0,1,0,1, $urandom, $urandom, 5'($urandom), 1,0,0,1);
            cmp_all($sformatf("stall%0d", i), held);
        end
        drive(0,0,0,1, 32'h000000B0, 32'h000000B1, 5'd11, 1,0,0,0);
        cmp_all("stall_release", '{1, 32'hB0, 32'hB1, 5'd11, 1,0,0,0, 1});

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            drive_random(3, 10, 25);
            cmp_all($sformatf("rnd%0d", i), model);
        end

`ifdef EX_MEM_PERF_EN
        drive(1,0,0,0, 0,0,0, 0,0,0,0);
        for (int i = 0; i < 4; i++) drive(0,0,0,1, i, i, 5'd1, 1,0,0,0);
        for (int i = 0; i < 2; i++) drive(0,0,1,1, i, i, 5'd1, 1,0,0,0);
        for (int i = 0; i < 3; i++) drive(0,1,0,1, i, i, 5'd1, 1,0,0,0);
        chk("perf_retired", perf_retired, 32'd4);
        chk("perf_bubble",  perf_bubble,  32'd2);
        chk("perf_stall",   perf_stall,   32'd3);
        dut.u_perf.r_retired_q = 32'hFFFF_FFFF;
        drive(0,0,0,1, 32'h1, 32'h1, 5'd1, 1,0,0,0);
        chk("perf_retired_wrap", perf_retired, 32'd0);
        drive(1,0,0,1, 32'h1, 32'h1, 5'd1, 1,0,0,0);
        chk("perf_stall_rst", perf_stall, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
